// File: rtl/vcfg_controller_pkg.sv
// Shared types and helpers for the vector configuration controller:
// vtype layout, config instruction fields, VLMAX and vtype legality.
package vcfg_controller_pkg;

  localparam int unsigned RISCV_MAX_VLEN = 65536;
  localparam logic [6:0]  OPC_V          = 7'h57;
  localparam logic [2:0]  OPCFG          = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DRAIN, RESP} vcfg_state_e;

  typedef enum logic [2:0] {
    EW8, EW16, EW32, EW64, EW128, EW256, EW512, EW1024
  } vsew_e;

  typedef enum logic [2:0] {
    LMUL_1, LMUL_2, LMUL_4, LMUL_8, LMUL_RSVD, LMUL_1_8, LMUL_1_4, LMUL_1_2
  } vlmul_e;

  localparam logic [2:0] VLUT_OFF  = 3'd0;
  localparam logic [2:0] VLUT_CB4  = 3'd1;
  localparam logic [2:0] VLUT_CB8  = 3'd2;
  localparam logic [2:0] VLUT_CB16 = 3'd3;

  // Tail policy is fixed agnostic in this unit, so bit 6 carries vma and
  // bit 7 carries vlut_pack (only writable through vsetvl).
  typedef struct packed {
    logic       vill;
    logic [2:0] vlut;
    logic       vlut_pack;
    logic       vma;
    vsew_e      vsew;
    vlmul_e     vlmul;
  } vtype_t;

  localparam vtype_t      VTYPE_VILL     = vtype_t'(12'h800);
  localparam int unsigned VTYPE_PACK_BIT = 7;
  localparam int unsigned ZIMM10_W       = 10;
  localparam int unsigned ZIMM11_W       = 11;

  // kind: 0x = vsetvli (kind[0] is zimm11 msb), 11 = vsetivli, 10 = vsetvl
  typedef struct packed {
    logic [1:0]          kind;
    logic [ZIMM10_W-1:0] zimm10;
    logic [4:0]          rs1;
    logic [2:0]          func3;
    logic [4:0]          rd;
    logic [6:0]          opcode;
  } rvv_instruction_t;

  localparam logic [1:0] KIND_VSETIVLI = 2'b11;
  localparam logic [1:0] KIND_VSETVL   = 2'b10;

  function automatic int unsigned vlmax(input vsew_e vsew, input vlmul_e vlmul,
                                        input int unsigned vlen);
    int unsigned base;
    base = vlen >> (32'd3 + 32'(vsew));
    case (vlmul)
      LMUL_2:   return base << 1;
      LMUL_4:   return base << 2;
      LMUL_8:   return base << 3;
      LMUL_1_2: return base >> 1;
      LMUL_1_4: return base >> 2;
      LMUL_1_8: return base >> 3;
      default:  return base;
    endcase
  endfunction

  function automatic logic vtype_illegal(input vsew_e vsew, input vlmul_e vlmul,
                                         input int unsigned elen);
    int unsigned sew;
    int unsigned lim;
    sew = 32'd8 << vsew;
    lim = elen;
    case (vlmul)
      LMUL_RSVD: return 1'b1;
      LMUL_1_2:  lim = elen >> 1;
      LMUL_1_4:  lim = elen >> 2;
      LMUL_1_8:  lim = elen >> 3;
      default:   lim = elen;
    endcase
    return sew > lim;
  endfunction

endpackage

// File: rtl/vcfg_inflight_cnt.sv
// Up/down count of vector ops issued to the lanes but not yet completed.
module vcfg_inflight_cnt #(
  parameter  int unsigned MaxInflight = 16,
  localparam int unsigned CNT_W       = $clog2(MaxInflight + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_i,
  input  logic             done_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({issue_i, done_i})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign cnt_o = cnt_q;

  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(issue_i && cnt_q == CNT_W'(MaxInflight)));
  no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(done_i && cnt_q == '0));

endmodule

// File: rtl/vcfg_controller.sv
// Executes vsetvli/vsetivli/vsetvl: computes vtype/vl, holds the architectural
// copies and stalls the commit while a LUT reconfiguration waits for drain.
module vcfg_controller
  import vcfg_controller_pkg::*;
#(
  parameter  int unsigned VLEN        = 4096,
  parameter  int unsigned ELEN        = 64,
  parameter  int unsigned MaxInflight = 16,
  localparam int unsigned VL_W        = $clog2(VLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cfg_req_valid_i,
  output logic            cfg_req_ready_o,
  input  logic [31:0]     cfg_instr_i,
  input  logic [63:0]     cfg_rs1_i,
  input  logic [63:0]     cfg_rs2_i,
  output logic            cfg_resp_valid_o,
  input  logic            cfg_resp_ready_i,
  output logic [63:0]     cfg_resp_rd_o,
  input  logic            op_issue_i,
  input  logic            op_done_i,
  output logic [11:0]     vtype_o,
  output logic [VL_W-1:0] vl_o,
  output logic            vstart_clr_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = $clog2(MaxInflight + 1);

  vcfg_state_e      state_q, state_d;
  rvv_instruction_t req_instr;
  logic [1:0]       kind_q;
  logic [9:0]       zimm_q;
  logic [4:0]       rs1_idx_q;
  logic             rd_x0_q;
  logic [63:0]      rs1_q, rs2_q;
  vtype_t           vtype_q, req_vt, new_vtype;
  logic [VL_W-1:0]  vl_q, new_vl, new_vlmax, cur_vlmax;
  logic [11:0]      vt_bits;
  logic [63:0]      avl;
  logic             accept, is_vsetivli, is_vsetvl, rs1_x0, keep_vl;
  logic             rsvd_nz, illegal, lut_change, commit;
  logic [CNT_W-1:0] inflight;

  vcfg_inflight_cnt #(.MaxInflight(MaxInflight)) u_inflight (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .issue_i (op_issue_i),
    .done_i  (op_done_i),
    .cnt_o   (inflight)
  );

  assign req_instr = rvv_instruction_t'(cfg_instr_i);
  assign accept    = cfg_req_valid_i && (state_q == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kind_q    <= '0;
      zimm_q    <= '0;
      rs1_idx_q <= '0;
      rd_x0_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else if (accept) begin
      kind_q    <= req_instr.kind;
      zimm_q    <= req_instr.zimm10;
      rs1_idx_q <= req_instr.rs1;
      rd_x0_q   <= (req_instr.rd == 5'd0);
      rs1_q     <= cfg_rs1_i;
      rs2_q     <= cfg_rs2_i;
    end
  end

  // Evaluated from the held request every cycle so DRAIN reuses the same result.
  always_comb begin
    is_vsetivli = (kind_q == KIND_VSETIVLI);
    is_vsetvl   = (kind_q == KIND_VSETVL);
    rsvd_nz     = 1'b0;
    if (is_vsetvl) begin
      vt_bits = rs2_q[11:0];
      rsvd_nz = |rs2_q[63:12];
    end else begin
      vt_bits = {1'b0, (is_vsetivli ? 1'b0 : kind_q[0]), zimm_q};
      vt_bits[VTYPE_PACK_BIT] = 1'b0;
    end
    req_vt    = vtype_t'(vt_bits);
    rs1_x0    = !is_vsetivli && (rs1_idx_q == 5'd0);
    keep_vl   = rs1_x0 && rd_x0_q;
    avl       = is_vsetivli ? 64'(rs1_idx_q) : rs1_q;
    new_vlmax = VL_W'(vlmax(req_vt.vsew, req_vt.vlmul, VLEN));
    cur_vlmax = VL_W'(vlmax(vtype_q.vsew, vtype_q.vlmul, VLEN));
    illegal   = vtype_illegal(req_vt.vsew, req_vt.vlmul, ELEN) || req_vt.vill ||
                rsvd_nz || (keep_vl && (new_vlmax != cur_vlmax));

    if (illegal)                   new_vl = '0;
    else if (keep_vl)              new_vl = vl_q;
    else if (rs1_x0)               new_vl = new_vlmax;
    else if (avl > 64'(new_vlmax)) new_vl = new_vlmax;
    else                           new_vl = avl[VL_W-1:0];

    new_vtype  = illegal ? VTYPE_VILL : req_vt;
    lut_change = (new_vtype.vlut != vtype_q.vlut) ||
                 (new_vtype.vlut_pack != vtype_q.vlut_pack);
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:  if (cfg_req_valid_i) state_d = CALC;
      CALC: begin
        if (lut_change && (inflight != '0)) begin
          state_d = DRAIN;
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    if (cfg_resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      vtype_q <= VTYPE_VILL;
      vl_q    <= '0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        vtype_q <= new_vtype;
        vl_q    <= new_vl;
      end
    end
  end

  assign cfg_req_ready_o  = (state_q == IDLE);
  assign cfg_resp_valid_o = (state_q == RESP);
  assign cfg_resp_rd_o    = 64'(vl_q);
  assign vtype_o          = vtype_q;
  assign vl_o             = vl_q;
  assign vstart_clr_o     = commit;
  assign busy_o           = (state_q != IDLE);

  cfg_instr_is_opcfg: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cfg_req_valid_i |-> (req_instr.func3 == OPCFG && req_instr.opcode == OPC_V));

endmodule

// File: tb/tb_vcfg_controller.sv
// Scoreboard bench: requests push expected {rd, vtype, first-valid cycle};
// a negedge monitor pops and compares on every accepted response.
module tb_vcfg_controller;

  localparam int VL_W = 13;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            req_valid = 1'b0, req_ready;
  logic [31:0]     instr = '0;
  logic [63:0]     rs1 = '0, rs2 = '0;
  logic            resp_valid, resp_ready = 1'b1;
  logic [63:0]     resp_rd;
  logic            op_issue = 1'b0, op_done = 1'b0;
  logic [11:0]     vtype;
  logic [VL_W-1:0] vl;
  logic            vstart_clr, busy;

  typedef struct {
    logic [63:0] rd;
    logic [11:0] vt;
    int          first;
  } exp_t;

  exp_t        sb[$];
  int          ntests = 0, nfail = 0, npush = 0, nclr = 0;
  int          cyc = 0, first = 0;
  bit          seen = 0;
  logic [63:0] held = '0;

  vcfg_controller #(.VLEN(4096), .ELEN(64), .MaxInflight(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_valid_i(req_valid), .cfg_req_ready_o(req_ready),
    .cfg_instr_i(instr), .cfg_rs1_i(rs1), .cfg_rs2_i(rs2),
    .cfg_resp_valid_o(resp_valid), .cfg_resp_ready_i(resp_ready),
    .cfg_resp_rd_o(resp_rd),
    .op_issue_i(op_issue), .op_done_i(op_done),
    .vtype_o(vtype), .vl_o(vl), .vstart_clr_o(vstart_clr), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    ntests++;
    nfail++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  function automatic logic [31:0] vsetvli(input logic [10:0] z, input logic [4:0] r1, input logic [4:0] rd);
    return {1'b0, z, r1, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] vsetivli(input logic [9:0] z, input logic [4:0] uimm, input logic [4:0] rd);
    return {2'b11, z, uimm, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] vsetvl(input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] rd);
    return {7'b1000000, r2, r1, 3'b111, rd, 7'h57};
  endfunction

  // Monitor: checks hold-stability while stalled and compares on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 0;
    end else begin
      if (vstart_clr) nclr++;
      if (resp_valid) begin
        if (!seen) begin
          seen = 1; first = cyc; held = resp_rd;
        end else begin
          chk("rd_stable", resp_rd, held);
        end
        chk("req_ready_low_in_resp", 64'(req_ready), 64'd0);
        if (resp_ready) begin
          if (sb.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL unexpected_resp: got rd 0x%0h expected no response", resp_rd);
          end else begin
            e = sb.pop_front();
            chk("resp_rd", resp_rd, e.rd);
            chk("vtype", 64'(vtype), 64'(e.vt));
            chk("vl", 64'(vl), e.rd);
            if (e.first >= 0) chk("latency", 64'(first), 64'(e.first));
          end
          seen = 0;
        end
      end
    end
  end

  // Entered and left at posedge+#1.
  task automatic do_req(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] erd, input logic [11:0] evt,
                        input bit push, input bit chk_lat);
    int t = 0;
    instr = ins; rs1 = a; rs2 = b; req_valid = 1'b1;
    while (!req_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!req_ready) begin
      bound_fail("req_accept");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (push) begin
      sb.push_back('{rd: erd, vt: evt, first: (chk_lat ? cyc + 1 : -1)});
      npush++;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || !req_ready) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (sb.size() != 0 || !req_ready) bound_fail("wait_idle");
  endtask

  task automatic ops(input logic is, input logic dn);
    op_issue = is; op_done = dn;
    @(posedge clk); #1;
    op_issue = 1'b0; op_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vtype", 64'(vtype), 64'h800);
    chk("rst_vl", 64'(vl), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_vstart_clr", 64'(vstart_clr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // e32 m1 AVL 200 -> VLMAX 128
    do_req(vsetvli(11'h010, 5'd1, 5'd5), 64'd200, 64'd0, 64'd128, 12'h010, 1, 1);
    wait_idle();
    // vsetivli e8 m8 uimm 17
    do_req(vsetivli(10'h003, 5'd17, 5'd5), 64'd0, 64'd0, 64'd17, 12'h003, 1, 1);
    wait_idle();
    // e8 mf8, rs1=x0 rd=x5 -> VLMAX 64
    do_req(vsetvli(11'h005, 5'd0, 5'd5), 64'd0, 64'd0, 64'd64, 12'h005, 1, 1);
    wait_idle();
    // EW128 exceeds ELEN -> vill
    do_req(vsetvli(11'h020, 5'd1, 5'd5), 64'd10, 64'd0, 64'd0, 12'h800, 1, 1);
    wait_idle();
    // reserved rs2 bit 20 -> vill
    do_req(vsetvl(5'd2, 5'd1, 5'd5), 64'd50, 64'h0010_0010, 64'd0, 12'h800, 1, 1);
    wait_idle();
    // CB4 e16 m2 with nothing in flight: no drain, VLMAX 512
    do_req(vsetvl(5'd2, 5'd1, 5'd5), 64'd1000, 64'h109, 64'd512, 12'h109, 1, 1);
    wait_idle();

    // CB4 -> CB16 with 3 ops in flight must drain
    repeat (3) ops(1'b1, 1'b0);
    do_req(vsetvl(5'd2, 5'd1, 5'd5), 64'd100, 64'h309, 64'd100, 12'h309, 1, 0);
    repeat (4) begin
      @(negedge clk);
      chk("drain_no_resp", 64'(resp_valid), 64'd0);
      chk("drain_busy", 64'(busy), 64'd1);
      chk("drain_vl_held", 64'(vl), 64'd512);
    end
    @(posedge clk); #1;
    ops(1'b0, 1'b1);
    ops(1'b1, 1'b1);
    ops(1'b0, 1'b1);
    @(negedge clk);
    chk("drain_hold_count1", 64'(resp_valid), 64'd0);
    ops(1'b0, 1'b1);
    @(negedge clk);
    chk("drain_commit_not_resp", 64'(resp_valid), 64'd0);
    chk("drain_vstart_clr", 64'(vstart_clr), 64'd1);
    @(negedge clk);
    chk("drain_resp_1cyc", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    wait_idle();

    // same LUT with 5 in flight: no drain; response held 4+ cycles
    repeat (5) ops(1'b1, 1'b0);
    resp_ready = 1'b0;
    do_req(vsetvl(5'd2, 5'd1, 5'd5), 64'd7, 64'h300, 64'd7, 12'h300, 1, 1);
    repeat (6) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    wait_idle();
    repeat (5) ops(1'b0, 1'b1);

    // reset while draining
    repeat (2) ops(1'b1, 1'b0);
    do_req(vsetvl(5'd2, 5'd1, 5'd5), 64'd9, 64'h100, 64'd0, 12'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_in_drain", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_vtype", 64'(vtype), 64'h800);
    chk("midrst_vl", 64'(vl), 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full 64-bit AVL compare: upper bits set -> VLMAX
    do_req(vsetvli(11'h010, 5'd1, 5'd5), 64'h1_0000_0005, 64'd0, 64'd128, 12'h010, 1, 1);
    wait_idle();
    // x0/x0 same VLMAX: vl kept, vtype updated
    do_req(vsetvli(11'h050, 5'd0, 5'd0), 64'd0, 64'd0, 64'd128, 12'h050, 1, 1);
    wait_idle();
    // x0/x0 different VLMAX -> vill
    do_req(vsetvli(11'h008, 5'd0, 5'd0), 64'd0, 64'd0, 64'd0, 12'h800, 1, 1);
    wait_idle();

    chk("vstart_clr_count", 64'(nclr), 64'(npush));
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
